// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an RV32I ALU-class instruction, forms the ALU
// operands and holds the result in a single-entry output register with
// valid/ready handshakes on both sides and a pipeline flush.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_control,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  localparam logic [4:0] CTRL_AND   = 5'b00000;
  localparam logic [4:0] CTRL_OR    = 5'b00001;
  localparam logic [4:0] CTRL_ADD   = 5'b00010;
  localparam logic [4:0] CTRL_XOR   = 5'b00011;
  localparam logic [4:0] CTRL_SLL   = 5'b00100;
  localparam logic [4:0] CTRL_SRL   = 5'b00101;
  localparam logic [4:0] CTRL_SUB   = 5'b00110;
  localparam logic [4:0] CTRL_SRA   = 5'b00111;
  localparam logic [4:0] CTRL_SLT   = 5'b01000;
  localparam logic [4:0] CTRL_SLTU  = 5'b01001;
  localparam logic [4:0] CTRL_PASSB = 5'b01010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Base operation selected by funct3; the f7 alternate forms (SUB, SRA)
  // are layered on top by the decoder.
  function automatic logic [4:0] f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  return CTRL_ADD;
      3'b001:  return CTRL_SLL;
      3'b010:  return CTRL_SLT;
      3'b011:  return CTRL_SLTU;
      3'b100:  return CTRL_XOR;
      3'b101:  return CTRL_SRL;
      3'b110:  return CTRL_OR;
      default: return CTRL_AND;
    endcase
  endfunction

  // ---- Stage p0: combinational decode of the incoming instruction ----
  logic [6:0]             opcode_p0;
  logic [2:0]             f3_p0;
  logic [6:0]             f7_p0;
  logic [4:0]             rd_p0;
  logic signed [XLEN-1:0] imm_i_p0;
  logic [XLEN-1:0]        imm_u_p0;
  logic [XLEN-1:0]        shamt_p0;
  logic [4:0]             ctrl_p0;
  logic [XLEN-1:0]        a_p0;
  logic [XLEN-1:0]        b_p0;
  logic                   ill_p0;
  logic                   capture_p0;

  assign opcode_p0 = instr[6:0];
  assign f3_p0     = instr[14:12];
  assign f7_p0     = instr[31:25];
  assign rd_p0     = instr[11:7];
  assign imm_i_p0  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u_p0  = {instr[31:12], 12'b0};
  assign shamt_p0  = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Operand and control selection; illegal encodings collapse to ADD of zeros.
  always_comb begin
    ctrl_p0 = CTRL_ADD;
    a_p0    = '0;
    b_p0    = '0;
    ill_p0  = 1'b0;
    case (opcode_p0)
      OPC_OP: begin
        a_p0    = rs1_data;
        b_p0    = rs2_data;
        ctrl_p0 = f3_ctrl(f3_p0);
        if (f7_p0 == F7_ALT && f3_p0 == 3'b000)      ctrl_p0 = CTRL_SUB;
        else if (f7_p0 == F7_ALT && f3_p0 == 3'b101) ctrl_p0 = CTRL_SRA;
        else if (f7_p0 != F7_ZERO)                   ill_p0  = 1'b1;
      end
      OPC_OPIMM: begin
        a_p0    = rs1_data;
        b_p0    = imm_i_p0;
        ctrl_p0 = f3_ctrl(f3_p0);
        if (f3_p0 == 3'b001) begin
          b_p0 = shamt_p0;
          if (f7_p0 != F7_ZERO) ill_p0 = 1'b1;
        end else if (f3_p0 == 3'b101) begin
          b_p0 = shamt_p0;
          if (f7_p0 == F7_ALT)        ctrl_p0 = CTRL_SRA;
          else if (f7_p0 != F7_ZERO)  ill_p0  = 1'b1;
        end
      end
      OPC_LUI: begin
        a_p0    = '0;
        b_p0    = imm_u_p0;
        ctrl_p0 = CTRL_PASSB;
      end
      OPC_AUIPC: begin
        a_p0    = pc;
        b_p0    = imm_u_p0;
        ctrl_p0 = CTRL_ADD;
      end
      default: ill_p0 = 1'b1;
    endcase
    if (ill_p0) begin
      ctrl_p0 = CTRL_ADD;
      a_p0    = '0;
      b_p0    = '0;
    end
  end

  // ---- Stage p1: single-entry output register ----
  logic            vld_p1;
  logic [XLEN-1:0] a_p1;
  logic [XLEN-1:0] b_p1;
  logic [4:0]      ctrl_p1;
  logic [4:0]      rd_p1;
  logic            wr_p1;
  logic            ill_p1;

  assign in_ready   = !vld_p1 || out_ready;
  assign capture_p0 = in_valid && in_ready && !flush;

  // Load on capture, drop on consume or flush, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      a_p1    <= '0;
      b_p1    <= '0;
      ctrl_p1 <= CTRL_AND;
      rd_p1   <= '0;
      wr_p1   <= 1'b0;
      ill_p1  <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (capture_p0) begin
      vld_p1  <= 1'b1;
      a_p1    <= a_p0;
      b_p1    <= b_p0;
      ctrl_p1 <= ctrl_p0;
      rd_p1   <= rd_p0;
      wr_p1   <= !ill_p0 && (rd_p0 != 5'd0);
      ill_p1  <= ill_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign alu_a       = a_p1;
  assign alu_b       = b_p1;
  assign alu_control = ctrl_p1;
  assign rd          = rd_p1;
  assign reg_write   = wr_p1;
  assign illegal     = ill_p1;

endmodule
